dac_frame_sched: RTL and testbench
==================================

# dac_frame_sched

Round-robin scheduler that shares the single 16-bit serial DAC shifter among `N_REQ` requesters. It sequences one complete DAC frame per grant:
- latch the word
- drive `cs`, `sck` and `cnt_sck`
- wait for the shifter's `ldac` load pulse
- enforce an inter-frame gap

It sits between the training-datapath producers and the DAC shifter; the shifter's `ldac` output is its completion feedback.

## Interface
- `N_REQ`, 4: number of requesters, 1..8.
- `SCK_HALF`, 2: clk cycles per `sck` half period, ≥2.
- `CS_GAP`, 2: minimum clk cycles with `cs` high between frames, ≥1.
- `LDAC_TO`, 63: watchdog limit in cycles for the HOLD+LDAC phases (timeout build only).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_state` in 1: global enable; low aborts and idles the block.
- `req` in N_REQ: per-requester frame request, level, held until `ack`.
- `req_data` in N_REQ*16: requester i word at bits [16i+15:16i].
- `ldac` in 1: load strobe from the shifter, active low.
- `ack` out N_REQ: one-hot, 1-cycle frame-complete pulse.
- `grant_id` out 3: index of the requester currently or last served.
- `busy` out 1: high from LOAD until the end of GAP.
- `data_sdi` out 16: word to the shifter, held stable for the whole frame.
- `en_dac` out 1: 1-cycle pulse in LOAD.
- `cs` out 1: DAC chip select, active low.
- `sck` out 1: serial clock, idles low.
- `cnt_sck` out 5: bit index 0..16 to the shifter.
- `ldac_err` out 1: sticky watchdog flag.

## Operation
- **Reset values:** `cs`=1; `sck`=0; `cnt_sck`=0; `data_sdi`=0; `en_dac`=0; `ack`=0; `busy`=0; `grant_id`=0; `ldac_err`=0; RR pointer=N_REQ-1; state IDLE.
- All outputs are registered.
- **IDLE:** if `key_state` and any `req`, grant the first set bit searching upward (wrapping) from pointer+1, then go to LOAD.
- **LOAD**, 1 cycle:
  - `data_sdi` ← granted word; `grant_id` ← index; `en_dac`=1; `busy`=1.
  - Next state SETUP.
- **SETUP**, 1 cycle: covers the shifter's data-register latency. Next state SHIFT with `cs`←0 and `cnt_sck`=0.
- **SHIFT:**
  - Each bit k (0..15) lasts 2·SCK_HALF cycles: `sck` low for the first SCK_HALF cycles, high for the second.
  - At the end of bit 15: `cnt_sck`←16, `sck`←0, `cs`←1; next state HOLD.
- **HOLD:**
  - `cs`=1 and `cnt_sck` held at 16, so the shifter can assert `ldac`.
  - On `ldac`=0, go to LDAC.
- **LDAC:** on `ldac` returning to 1:
  - `ack[grant_id]`=1 for one cycle; pointer ← `grant_id`.
  - `cnt_sck`←0; go to GAP.
- **GAP:** hold `cs`=1 for CS_GAP cycles, then `busy`←0 and return to IDLE. A new grant may be taken on the IDLE cycle that follows.
- **Requester dropping `req` mid-frame:** the frame still completes and `ack` still pulses. `req` is sampled only in IDLE.
- **Pending requests:** new `req` bits that rise during a frame wait for the next arbitration; no preemption.
- **`key_state`=0 in any state:**
  - Next cycle: IDLE, `cs`=1, `sck`=0, `cnt_sck`=0, `busy`=0.
  - No `ack`; pointer unchanged; `data_sdi` holds its value.
- **Async reset mid-frame:** all outputs go to their reset values immediately.

## Timing
- LOAD→first `cs` low: 2 cycles.
- `cs` low duration: 32·SCK_HALF cycles (64 at default).
- `data_sdi` is stable from LOAD+1 until the next LOAD.
- Shifter bit k is presented one cycle after `cnt_sck`=k. The first `sck` rise comes SCK_HALF cycles after that change, so `sdi` setup is ≥ SCK_HALF−1 cycles.
- `ack` appears one cycle after `ldac` is sampled high in LDAC.
- Minimum frame period: 2 + 32·SCK_HALF + (HOLD+LDAC shifter latency, about 14) + CS_GAP + 1 cycles.

## Configuration
- **`DAC_FRAME_SCHED_TIMEOUT_EN` defined:**
  - A watchdog counts cycles spent in HOLD+LDAC.
  - Reaching LDAC_TO sets `ldac_err` (sticky until reset).
  - It pulses `ack[grant_id]` (the frame is dropped) and enters GAP.
- **Undefined:** HOLD and LDAC wait indefinitely; `ldac_err` is tied to 0.

## Structure
- **Package `dac_pkg`:**
  - State enum (IDLE, LOAD, SETUP, SHIFT, HOLD, LDAC, GAP).
  - `DAC_BITS`=16, `CNT_LOAD`=5'd16, word typedef `dac_word_t`.
- **Sub-module `rr_arbiter`:** combinational round-robin pick.
  - Inputs: `req`, pointer.
  - Outputs: one-hot grant, index, valid.

## Test plan
- Reset, then `key_state`=1, `req`=4'b0001, word 0xA5C3 → `cs` low for 64 cycles; `cnt_sck` steps 0..15 every 4 cycles then holds at 16; the shifter's `sdi` reproduces 0xA5C3 MSB first on `sck` rises; `ack`=4'b0001 once.
- `req`=4'b1111 held, distinct words → grants in order 0,1,2,3,0; each `ack` one-hot; `cs` high for ≥2 cycles between frames.
- `key_state` dropped at bit 7 → next cycle `cs`=1, `sck`=0, `cnt_sck`=0, no `ack`; after re-enable the same requester is granted first.
- `req[2]` deasserted during SHIFT → frame completes and `ack`=4'b0100.
- Timeout build, shifter `ldac` stuck high → after 63 cycles in HOLD, `ldac_err`=1, `ack` pulses, the next request is served; without the macro the block stays in HOLD and `ldac_err`=0.
- Async reset asserted mid-SHIFT → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame scheduler.
// Build option: DAC_FRAME_SCHED_TIMEOUT_EN enables the HOLD/LDAC watchdog in dac_frame_sched.
package dac_pkg;

    localparam int DAC_BITS = 16;
    localparam logic [4:0] CNT_LOAD = 5'd16;

    typedef logic [DAC_BITS-1:0] dac_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_LDAC,
        ST_GAP
    } state_t;

endpackage

// File: rtl/dac_frame_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       idx,
    output logic             vld
);

    // Walk the candidates in priority order; the first requesting one wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!vld && (k == ((int'(ptr) + i) % N_REQ)) && req[k]) begin
                    vld    = 1'b1;
                    idx    = 3'(k);
                    gnt[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dac_frame_sched.sv
// Round-robin scheduler sharing one 16-bit serial DAC shifter among N_REQ requesters.
// Sequences LOAD, SETUP, SHIFT (cs/sck/cnt_sck), HOLD/LDAC (wait for the shifter's
// ldac pulse) and an inter-frame GAP.
// Build option: DAC_FRAME_SCHED_TIMEOUT_EN adds a watchdog on HOLD+LDAC that sets the
// sticky ldac_err, drops the frame with an ack and moves on to GAP.
module dac_frame_sched
    import dac_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 2,
    parameter int LDAC_TO  = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_state,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*16-1:0]   req_data,
    input  logic                  ldac,
    output logic [N_REQ-1:0]      ack,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic [15:0]           data_sdi,
    output logic                  en_dac,
    output logic                  cs,
    output logic                  sck,
    output logic [4:0]            cnt_sck,
    output logic                  ldac_err
);

    localparam int PH_W  = $clog2(2 * SCK_HALF);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * SCK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_RISE = PH_W'(SCK_HALF - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       grant_id_q, grant_id_d;
    dac_word_t        data_sdi_q, data_sdi_d;
    logic             en_dac_q, en_dac_d;
    logic             busy_q, busy_d;
    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic [4:0]       cnt_sck_q, cnt_sck_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             finish;

    logic [N_REQ-1:0] arb_gnt;
    logic [2:0]       arb_idx;
    logic             arb_vld;
    dac_word_t        arb_word;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    // Select the granted requester's word; arb_gnt is one-hot so an OR-mux suffices.
    always_comb begin
        arb_word = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_gnt[k]) arb_word = arb_word | req_data[k*16 +: 16];
        end
    end

`ifdef DAC_FRAME_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(LDAC_TO + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(LDAC_TO - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            ldac_err_q, ldac_err_d;
    assign ldac_err = ldac_err_q;
`else
    // No watchdog: flag is permanently clear (LDAC_TO only shapes the watchdog build).
    assign ldac_err = 1'b0 & (LDAC_TO > 0);
`endif

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        data_sdi_d = data_sdi_q;
        en_dac_d   = 1'b0;
        busy_d     = busy_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        cnt_sck_d  = cnt_sck_q;
        ack_d      = '0;
        ph_d       = ph_q;
        gap_d      = gap_q;
        finish     = 1'b0;
`ifdef DAC_FRAME_SCHED_TIMEOUT_EN
        wd_d       = wd_q;
        ldac_err_d = ldac_err_q;
`endif
        if (!key_state) begin
            // Abort: idle the bus, keep the pointer and the last word.
            state_d   = ST_IDLE;
            cs_d      = 1'b1;
            sck_d     = 1'b0;
            cnt_sck_d = '0;
            busy_d    = 1'b0;
            ph_d      = '0;
            gap_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        state_d    = ST_LOAD;
                        data_sdi_d = arb_word;
                        grant_id_d = arb_idx;
                        en_dac_d   = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                ST_LOAD: state_d = ST_SETUP;
                ST_SETUP: begin
                    // One cycle for the shifter's data register, then open the frame.
                    state_d   = ST_SHIFT;
                    cs_d      = 1'b0;
                    cnt_sck_d = '0;
                    sck_d     = 1'b0;
                    ph_d      = '0;
                end
                ST_SHIFT: begin
                    if (ph_q == PH_LAST) begin
                        ph_d  = '0;
                        sck_d = 1'b0;
                        if (cnt_sck_q == 5'd15) begin
                            cnt_sck_d = CNT_LOAD;
                            cs_d      = 1'b1;
                            state_d   = ST_HOLD;
`ifdef DAC_FRAME_SCHED_TIMEOUT_EN
                            wd_d      = '0;
`endif
                        end else begin
                            cnt_sck_d = cnt_sck_q + 5'd1;
                        end
                    end else begin
                        ph_d = ph_q + 1'b1;
                        if (ph_q == PH_RISE) sck_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!ldac) state_d = ST_LDAC;
                end
                ST_LDAC: begin
                    if (ldac) finish = 1'b1;
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_d  = 1'b0;
                        gap_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef DAC_FRAME_SCHED_TIMEOUT_EN
            // Watchdog: a normal ldac completion wins over a same-cycle expiry.
            if (state_q == ST_HOLD || state_q == ST_LDAC) begin
                wd_d = wd_q + 1'b1;
                if (!finish && wd_q == WD_LAST) begin
                    ldac_err_d = 1'b1;
                    finish     = 1'b1;
                end
            end
`endif
            if (finish) begin
                for (int k = 0; k < N_REQ; k++) ack_d[k] = (grant_id_q == 3'(k));
                ptr_d     = grant_id_q;
                cnt_sck_d = '0;
                gap_d     = '0;
                state_d   = ST_GAP;
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'(N_REQ - 1);
            grant_id_q <= '0;
            data_sdi_q <= '0;
            en_dac_q   <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            cnt_sck_q  <= '0;
            ack_q      <= '0;
            ph_q       <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            data_sdi_q <= data_sdi_d;
            en_dac_q   <= en_dac_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            cnt_sck_q  <= cnt_sck_d;
            ack_q      <= ack_d;
            ph_q       <= ph_d;
            gap_q      <= gap_d;
        end
    end

`ifdef DAC_FRAME_SCHED_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q       <= '0;
            ldac_err_q <= 1'b0;
        end else begin
            wd_q       <= wd_d;
            ldac_err_q <= ldac_err_d;
        end
    end
`endif

    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign data_sdi = data_sdi_q;
    assign en_dac   = en_dac_q;
    assign cs       = cs_q;
    assign sck      = sck_q;
    assign cnt_sck  = cnt_sck_q;

endmodule

// File: tb/tb_dac_frame_sched.sv
// Directed bench for dac_frame_sched with a behavioural shifter model
// (sdi presented one cycle after cnt_sck, ldac low pulse after each frame).
module tb_dac_frame_sched;

    localparam int SH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_state;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic        ldac = 1'b1;
    logic [3:0]  ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic [15:0] data_sdi;
    logic        en_dac;
    logic        cs;
    logic        sck;
    logic [4:0]  cnt_sck;
    logic        ldac_err;

    logic [15:0] words [4];

    int checks = 0;
    int failures = 0;

    // shifter / monitor state
    logic        stuck = 1'b0;
    logic        prev_cs, prev_sck, sdi_m, have_frame;
    logic [15:0] shreg, last_word;
    int          run_len, last_low, high_run, min_gap, pat_err, ack_cnt, ld_cnt;

    dac_frame_sched dut (
        .clk(clk), .rst_n(rst_n), .key_state(key_state), .req(req), .req_data(req_data),
        .ldac(ldac), .ack(ack), .grant_id(grant_id), .busy(busy), .data_sdi(data_sdi),
        .en_dac(en_dac), .cs(cs), .sck(sck), .cnt_sck(cnt_sck), .ldac_err(ldac_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Shifter model and frame monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sck = 1'b0; sdi_m = 1'b0; have_frame = 1'b0;
            shreg = '0; last_word = '0; run_len = 0; last_low = 0; high_run = 0;
            min_gap = 9999; pat_err = 0; ack_cnt = 0; ld_cnt = 0; ldac = 1'b1;
        end else begin
            if (!cs) begin
                if (cnt_sck != 5'(run_len / (2*SH)) || sck != ((run_len % (2*SH)) >= SH))
                    pat_err++;
                run_len++;
            end
            if (cs && !prev_cs) begin
                last_low = run_len;
                if (cnt_sck == 5'd16) begin
                    last_word = shreg;
                    if (!stuck) ld_cnt = 1;
                end
                run_len = 0;
                have_frame = 1'b1;
            end
            if (!cs && prev_cs && have_frame && high_run < min_gap) min_gap = high_run;
            high_run = cs ? high_run + 1 : 0;
            if (sck && !prev_sck) shreg = {shreg[14:0], sdi_m};
            sdi_m = (cnt_sck < 5'd16) ? data_sdi[15 - int'(cnt_sck)] : 1'b0;
            if (ack != 4'b0) ack_cnt++;
            if (ld_cnt != 0) begin
                ld_cnt++;
                if (ld_cnt == 4) ldac = 1'b0;
                else if (ld_cnt == 6) begin ldac = 1'b1; ld_cnt = 0; end
            end
            prev_cs = cs;
            prev_sck = sck;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output logic [3:0] a, output logic ok);
        a = '0; ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (ack != 4'b0) begin a = ack; ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cnt(input logic [4:0] v, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (cnt_sck == v) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        logic [3:0] a;
        logic       ok;
        int         acks0, k;
        int         order [5] = '{0, 1, 2, 3, 0};

        words[0] = 16'hA5C3; words[1] = 16'h1234; words[2] = 16'hBEEF; words[3] = 16'h0F0F;
        req_data = {words[3], words[2], words[1], words[0]};
        key_state = 1'b0; req = '0;
        do_reset();
        @(negedge clk);

        // reset values
        chk("rst_cs", cs, 1); chk("rst_sck", sck, 0); chk("rst_cnt", cnt_sck, 0);
        chk("rst_data", data_sdi, 0); chk("rst_en", en_dac, 0); chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0); chk("rst_gid", grant_id, 0); chk("rst_err", ldac_err, 0);

        // single frame from requester 0
        key_state = 1'b1; req = 4'b0001;
        @(negedge clk);
        chk("t1_en_dac", en_dac, 1); chk("t1_busy", busy, 1); chk("t1_data", data_sdi, 16'hA5C3);
        @(negedge clk);
        chk("t1_en_pulse", en_dac, 0); chk("t1_cs_setup", cs, 1);
        @(negedge clk);
        chk("t1_cs_low", cs, 0);
        wait_ack(a, ok); req = '0;
        chk("t1_ack_seen", 32'(ok), 1); chk("t1_ack", a, 4'b0001);
        chk("t1_cs_len", last_low, 64); chk("t1_word", last_word, 16'hA5C3);
        chk("t1_pattern", pat_err, 0);
        repeat (4) @(negedge clk);
        chk("t1_ack_once", ack_cnt, 1); chk("t1_idle", busy, 0);

        // all four requesting: round-robin order from reset
        do_reset();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_ack(a, ok);
            if (f == 4) req = '0;
            chk("t2_ack_seen", 32'(ok), 1);
            chk($sformatf("t2_ack%0d", f), a, 32'(1 << order[f]));
            chk($sformatf("t2_word%0d", f), last_word, words[order[f]]);
            chk($sformatf("t2_len%0d", f), last_low, 64);
        end
        chk("t2_gap", 32'(min_gap >= 2), 1); chk("t2_pattern", pat_err, 0);

        // key_state drop at bit 7, then re-enable: same requester first
        do_reset();
        req = 4'b0010;
        wait_cnt(5'd7, ok);
        chk("t3_bit7", 32'(ok), 1);
        acks0 = ack_cnt;
        key_state = 1'b0;
        @(negedge clk);
        chk("t3_cs", cs, 1); chk("t3_sck", sck, 0); chk("t3_cnt", cnt_sck, 0);
        chk("t3_busy", busy, 0); chk("t3_data", data_sdi, 16'h1234);
        repeat (10) @(negedge clk);
        chk("t3_no_ack", ack_cnt, acks0);
        req = 4'b1010; key_state = 1'b1;
        wait_ack(a, ok); req = '0;
        chk("t3_ack_seen", 32'(ok), 1); chk("t3_regrant", a, 4'b0010);

        // req[2] dropped mid-shift: frame still completes
        do_reset();
        req = 4'b0100;
        wait_cnt(5'd3, ok);
        req = '0;
        wait_ack(a, ok);
        chk("t4_ack_seen", 32'(ok), 1); chk("t4_ack", a, 4'b0100);
        chk("t4_word", last_word, 16'hBEEF);
        repeat (6) @(negedge clk);
        chk("t4_no_refr", busy, 0);

        // ldac stuck high
        do_reset();
        stuck = 1'b1; req = 4'b0001;
        wait_cnt(5'd16, ok);
        chk("t5_hold", 32'(ok), 1);
        acks0 = ack_cnt;
`ifdef DAC_FRAME_SCHED_TIMEOUT_EN
        k = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ack != 4'b0) begin k = n; break; end
        end
        req = '0; stuck = 1'b0;
        chk("t5_to_cycles", k, 63); chk("t5_to_ack", ack, 4'b0001); chk("t5_err", ldac_err, 1);
        req = 4'b0010;
        wait_ack(a, ok); req = '0;
        chk("t5_next_ack", a, 4'b0010); chk("t5_err_sticky", ldac_err, 1);
`else
        k = 0;
        repeat (100) @(negedge clk);
        chk("t5_busy", busy, 1); chk("t5_cnt", cnt_sck, 16); chk("t5_cs", cs, 1);
        chk("t5_err", ldac_err, 0); chk("t5_no_ack", ack_cnt, acks0 + k);
        req = '0; stuck = 1'b0;
`endif

        // async reset mid-shift
        do_reset();
        req = 4'b0100;
        wait_cnt(5'd5, ok);
        chk("t6_shift", 32'(ok), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_cs", cs, 1); chk("t6_sck", sck, 0); chk("t6_cnt", cnt_sck, 0);
        chk("t6_data", data_sdi, 0); chk("t6_busy", busy, 0); chk("t6_gid", grant_id, 0);
        chk("t6_en", en_dac, 0); chk("t6_ack", ack, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench time limit");
    end

endmodule
